// File: rtl/egg_timer_ctrl_pkg.sv
// Shared definitions for the egg timer controller: state encodings and BCD digit constants.
package egg_timer_ctrl_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DONE  = 3'd3
  } state_e;

  localparam logic [DIGIT_W-1:0] BCD_NINE = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_FIVE = 4'd5;

endpackage

// File: rtl/egg_timer_ctrl_bcd2_incr.sv
// Registered two-digit BCD incrementer; wraps from MAX_TENS:9 back to 00.
module bcd2_incr
  import egg_timer_ctrl_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX_TENS = BCD_FIVE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic [2*DIGIT_W-1:0] rst_val,
  output logic [DIGIT_W-1:0]   tens,
  output logic [DIGIT_W-1:0]   units
);

  always_ff @(posedge clk) begin
    if (reset) begin
      tens  <= rst_val[2*DIGIT_W-1:DIGIT_W];
      units <= rst_val[DIGIT_W-1:0];
    end else if (inc) begin
      if (units == BCD_NINE) begin
        units <= '0;
        tens  <= (tens == MAX_TENS) ? '0 : tens + DIGIT_W'(1);
      end else begin
        units <= units + DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer sequencer: programs mm:ss, drives load/enable of the BCD countdown and
// stops it at 00:00, then sounds the alarm for a fixed number of 1 Hz ticks.
module egg_timer_ctrl
  import egg_timer_ctrl_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] DEFAULT_MIN = 4'd3,
  parameter logic [7:0]         ALARM_TICKS = 8'd10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1hz,
  input  logic               btn_start,
  input  logic               btn_stop,
  input  logic               btn_sec_inc,
  input  logic               btn_min_inc,
  input  logic [DIGIT_W-1:0] seconds,
  input  logic [DIGIT_W-1:0] tens_seconds,
  input  logic [DIGIT_W-1:0] minutes,
  input  logic [DIGIT_W-1:0] tens_minutes,
  output logic [DIGIT_W-1:0] seconds_prog,
  output logic [DIGIT_W-1:0] tens_seconds_prog,
  output logic [DIGIT_W-1:0] minutes_prog,
  output logic [DIGIT_W-1:0] tens_minutes_prog,
  output logic               timer_load,
  output logic               main_enable,
  output logic               alarm,
  output logic [STATE_W-1:0] state
);

  state_e     state_q;
  logic [7:0] alarm_cnt;
  logic       all_zero;
  logic       prog_zero;
  logic       in_idle;

  assign in_idle   = (state_q == ST_IDLE);
  assign all_zero  = ({tens_minutes, minutes, tens_seconds, seconds} == '0);
  assign prog_zero = ({tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog} == '0);
  assign state     = STATE_W'(state_q);

  // Gated straight off the digits so the tick landing on 00:00 can never be followed by another decrement.
  assign main_enable = (state_q == ST_RUN) && !all_zero;

  bcd2_incr #(.MAX_TENS(BCD_FIVE)) u_sec_prog (
    .clk     (clk),
    .reset   (reset),
    .inc     (btn_sec_inc && in_idle),
    .rst_val (8'h00),
    .tens    (tens_seconds_prog),
    .units   (seconds_prog)
  );

  bcd2_incr #(.MAX_TENS(BCD_NINE)) u_min_prog (
    .clk     (clk),
    .reset   (reset),
    .inc     (btn_min_inc && in_idle),
    .rst_val ({4'd0, DEFAULT_MIN}),
    .tens    (tens_minutes_prog),
    .units   (minutes_prog)
  );

  // timer_load and alarm are updated together with state so they track it with no extra latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_load <= 1'b1;
      alarm      <= 1'b0;
      alarm_cnt  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (btn_start && !btn_stop && !prog_zero) begin
            state_q    <= ST_RUN;
            timer_load <= 1'b0;
          end
        end
        ST_RUN: begin
          if (all_zero) begin
            state_q   <= ST_DONE;
            alarm     <= 1'b1;
            alarm_cnt <= '0;
          end else if (btn_stop) begin
            state_q <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (btn_stop) begin
            state_q    <= ST_IDLE;
            timer_load <= 1'b1;
          end else if (btn_start) begin
            state_q <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (btn_start || btn_stop || (tick_1hz && alarm_cnt == ALARM_TICKS - 8'd1)) begin
            state_q    <= ST_IDLE;
            timer_load <= 1'b1;
            alarm      <= 1'b0;
          end else if (tick_1hz) begin
            alarm_cnt <= alarm_cnt + 8'd1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          timer_load <= 1'b1;
          alarm      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed bench for egg_timer_ctrl with a behavioural model of the BCD countdown datapath.
module tb_egg_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_stop = 1'b0;
  logic       btn_sec_inc = 1'b0;
  logic       btn_min_inc = 1'b0;
  logic [3:0] seconds, tens_seconds, minutes, tens_minutes;
  logic [3:0] seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog;
  logic       timer_load, main_enable, alarm;
  logic [2:0] state;
  logic [15:0] digits;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  egg_timer_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .tick_1hz          (tick_1hz),
    .btn_start         (btn_start),
    .btn_stop          (btn_stop),
    .btn_sec_inc       (btn_sec_inc),
    .btn_min_inc       (btn_min_inc),
    .seconds           (seconds),
    .tens_seconds      (tens_seconds),
    .minutes           (minutes),
    .tens_minutes      (tens_minutes),
    .seconds_prog      (seconds_prog),
    .tens_seconds_prog (tens_seconds_prog),
    .minutes_prog      (minutes_prog),
    .tens_minutes_prog (tens_minutes_prog),
    .timer_load        (timer_load),
    .main_enable       (main_enable),
    .alarm             (alarm),
    .state             (state)
  );

  // Countdown datapath model; decrements wrap 00:00 -> 99:59 so any missing gate shows up.
  always @(posedge clk) begin
    if (timer_load) begin
      seconds      <= seconds_prog;
      tens_seconds <= tens_seconds_prog;
      minutes      <= minutes_prog;
      tens_minutes <= tens_minutes_prog;
    end else if (main_enable && tick_1hz) begin
      if (seconds != 4'd0) seconds <= seconds - 4'd1;
      else begin
        seconds <= 4'd9;
        if (tens_seconds != 4'd0) tens_seconds <= tens_seconds - 4'd1;
        else begin
          tens_seconds <= 4'd5;
          if (minutes != 4'd0) minutes <= minutes - 4'd1;
          else begin
            minutes      <= 4'd9;
            tens_minutes <= (tens_minutes == 4'd0) ? 4'd9 : tens_minutes - 4'd1;
          end
        end
      end
    end
  end

  assign digits = {tens_minutes, minutes, tens_seconds, seconds};

  task automatic cyc(input logic st, input logic sp, input logic si, input logic mi, input logic tk);
    @(negedge clk);
    btn_start = st; btn_stop = sp; btn_sec_inc = si; btn_min_inc = mi; tick_1hz = tk;
    @(posedge clk);
    #1;
    btn_start = 1'b0; btn_stop = 1'b0; btn_sec_inc = 1'b0; btn_min_inc = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset and default programming
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_state", state, 0);
    chk("rst_load", timer_load, 1);
    chk("rst_alarm", alarm, 0);
    chk("rst_en", main_enable, 0);
    chk("rst_prog", {tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog}, 32'h0300);
    chk("rst_digits", digits, 32'h0300);

    // Full 3-minute run to DONE
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("run_state", state, 1);
    chk("run_en", main_enable, 1);
    chk("run_load", timer_load, 0);
    ticks(179);
    chk("run_179", digits, 32'h0001);
    ticks(1);
    chk("run_180_digits", digits, 32'h0000);
    chk("run_180_en", main_enable, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("done_state", state, 3);
    chk("done_alarm", alarm, 1);

    // Alarm times out on the 10th tick, digits never wrap
    ticks(9);
    chk("done_9_state", state, 3);
    chk("done_9_digits", digits, 32'h0000);
    ticks(1);
    chk("done_10_state", state, 0);
    chk("done_10_alarm", alarm, 0);
    chk("done_10_load", timer_load, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reload_digits", digits, 32'h0300);

    // Programming wraps
    repeat (59) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sec_59", {tens_seconds_prog, seconds_prog}, 32'h59);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sec_wrap", {tens_seconds_prog, seconds_prog}, 32'h00);
    chk("sec_wrap_min", {tens_minutes_prog, minutes_prog}, 32'h03);
    repeat (96) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("min_99", {tens_minutes_prog, minutes_prog}, 32'h99);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("min_wrap", {tens_minutes_prog, minutes_prog}, 32'h00);

    // Start with 00:00 programmed is ignored
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("zero_start_state", state, 0);
    chk("zero_start_en", main_enable, 0);

    // 00:01 run: next tick after reaching 00:00 must not wrap
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("p1_digits", digits, 32'h0001);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("p1_run", state, 1);
    ticks(1);
    chk("p1_zero", digits, 32'h0000);
    chk("p1_en", main_enable, 0);
    ticks(1);
    chk("p1_nowrap", digits, 32'h0000);
    chk("p1_done", state, 3);
    ticks(1);
    chk("p1_nowrap2", digits, 32'h0000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("p1_stop_idle", state, 0);

    // Pause, resume, cancel
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("p2_digits", digits, 32'h0101);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(3);
    chk("p2_run3", digits, 32'h0058);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("inc_in_run", {tens_seconds_prog, seconds_prog}, 32'h01);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pause_state", state, 2);
    chk("pause_en", main_enable, 0);
    ticks(5);
    chk("pause_hold", digits, 32'h0058);
    chk("pause_hold_state", state, 2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("resume_state", state, 1);
    ticks(1);
    chk("resume_tick", digits, 32'h0057);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pause2_state", state, 2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("cancel_state", state, 0);
    chk("cancel_load", timer_load, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("cancel_reload", digits, 32'h0101);

    // Simultaneous start+stop: stop wins
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("both_run", state, 2);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("both_pause", state, 0);

    // Reset mid-run behaves like power-up
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(2);
    chk("pre_rst_state", state, 1);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_prog", {tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog}, 32'h0300);
    chk("mid_rst_alarm", alarm, 0);
    chk("mid_rst_load", timer_load, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
